// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: bubble encoding, reset PC default,
// the IF/ID register payload type and the opcode constants used by decode.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr    = NOP_INSTR;
        b.pc       = 32'h0000_0000;
        b.pc_plus4 = 32'h0000_0000;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear (load bubble) beats enable; synchronous
// active-high reset also loads the bubble.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en_i,
    input  logic  clr_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t stage_q;
    ifid_t stage_d;

    // Next-state selection: clear, load, or hold.
    always_comb begin
        stage_d = stage_q;
        if (clr_i) begin
            stage_d = ifid_bubble();
        end else if (en_i) begin
            stage_d = d_i;
        end else begin
            stage_d = stage_q;
        end
    end

    // Stage register with synchronous reset to bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= ifid_bubble();
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register with redirect/stall/wait-state
// handling, feeding the IF/ID register that presents the instruction to decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            ImemReady,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    logic [XLEN-1:0] pcf_q;
    logic [XLEN-1:0] pcf_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic            ifid_en_s;
    logic            ifid_clr_s;
    ifid_t           ifid_d_s;
    ifid_t           ifid_q_s;

    assign pc_plus4_s = pcf_q + 32'd4;

    // PC next-state: a redirect abandons any stall or outstanding fetch.
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = {PCTargetE[XLEN-1:2], 2'b00};
        end else if (StallF || !ImemReady) begin
            pcf_d = pcf_q;
        end else begin
            pcf_d = pc_plus4_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_d;
        end
    end

    // A fetch stalled in F while D advances must not be captured twice.
    assign ifid_en_s  = !StallD;
    assign ifid_clr_s = FlushD || (!StallD && (StallF || !ImemReady));

    assign ifid_d_s.instr    = ImemRdata;
    assign ifid_d_s.pc       = pcf_q;
    assign ifid_d_s.pc_plus4 = pc_plus4_s;
    assign ifid_d_s.valid    = 1'b1;

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (ifid_en_s),
        .clr_i (ifid_clr_s),
        .d_i   (ifid_d_s),
        .q_o   (ifid_q_s)
    );

    assign PCF      = pcf_q;
    assign InstrD   = ifid_q_s.instr;
    assign PCD      = ifid_q_s.pc;
    assign PCPlus4D = ifid_q_s.pc_plus4;
    assign ValidD   = ifid_q_s.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random control
// traffic, compared against a behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks;
    int errors;

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReady (ImemReady),
        .ImemRdata (ImemRdata),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of controls, advance the model, then compare all outputs.
    task automatic step(input string tag, input logic rst, input logic sf, input logic sd,
                        input logic fd, input logic br, input logic [31:0] tgt, input logic rdy);
        logic [31:0] n_pc;
        reset     = rst;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcE    = br;
        PCTargetE = tgt;
        ImemReady = rdy;
        ImemRdata = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;

        if (rst)            n_pc = 32'h0000_0000;
        else if (br)        n_pc = tgt & 32'hFFFF_FFFC;
        else if (sf || !rdy) n_pc = m_pc;
        else                n_pc = m_pc + 32'd4;

        if (rst || fd || (!sd && (sf || !rdy))) begin
            m_instr = 32'h0000_0013; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (!sd) begin
            m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else begin
            m_valid = m_valid;
        end
        m_pc = n_pc;

        @(posedge clk);
        #1;
        chk({tag, ".PCF"},      PCF,      m_pc);
        chk({tag, ".InstrD"},   InstrD,   m_instr);
        chk({tag, ".PCD"},      PCD,      m_pcd);
        chk({tag, ".PCPlus4D"}, PCPlus4D, m_pc4);
        chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, m_valid});
    endtask

    initial begin
        checks = 0; errors = 0;
        m_pc = 32'd0; m_instr = 32'h13; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'd0; ImemReady = 1'b0; ImemRdata = 32'd0;

        // reset held two cycles
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst.ValidD_lit", {31'd0, ValidD}, 32'd0);
        // sequential fetch
        step("seq0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq0.word0", InstrD, mem_word(32'd0));
        step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq1.PCF8", PCF, 32'd8);
        // stall F and D at PCF=8
        step("stl0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step("stl1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("stl1.PCD4", PCD, 32'd4);
        step("stl2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("stl2.PCD8", PCD, 32'd8);
        step("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        // redirect to unaligned target at PCF=0x10
        step("br0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        chk("br0.PCF100", PCF, 32'h100);
        step("br1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("br1.PCD100", PCD, 32'h100);
        // wait states at 0x20
        step("br2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1);
        step("ws0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step("ws1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step("ws2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("ws2.bubble", InstrD, 32'h0000_0013);
        step("ws3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("ws3.PCD20", PCD, 32'h20);
        // redirect overrides stall and wait state
        step("bro", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        chk("bro.PCF40", PCF, 32'h40);
        step("seq3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        step("fls", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        // PC wrap
        step("wr0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step("wr1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wr1.PCF0", PCF, 32'd0);
        chk("wr1.PC4wrap", PCPlus4D, 32'd0);
        step("wr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        // reset wins over stall and redirect
        step("rstw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0444, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline: owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. It sits directly upstream of the decode-stage `controller`, which consumes `InstrD` fields (`op`, `funct3`, `funct7b5`). It applies branch/jump redirects from Execute, hazard-unit stalls and flushes, and instruction-memory wait states, inserting NOP bubbles where required.

## Interface
- `XLEN`, 32: datapath/PC width; only 32 supported.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `StallF` in 1: hold PC (hazard unit).
- `StallD` in 1: hold IF/ID register.
- `FlushD` in 1: replace IF/ID contents with bubble.
- `PCSrcE` in 1: redirect taken in Execute.
- `PCTargetE` in 32: redirect target.
- `ImemReady` in 1: `ImemRdata` valid for current `PCF` this cycle.
- `ImemRdata` in 32: instruction word at `PCF` (combinational memory read).
- `PCF` out 32: fetch address to instruction memory.
- `InstrD` out 32: decode-stage instruction.
- `PCD` out 32: PC of `InstrD`.
- `PCPlus4D` out 32: `PCD + 4`.
- `ValidD` out 1: `InstrD` is a real fetched instruction (0 = bubble).

## Operation
- Bubble = `InstrD` 32'h0000_0013 (addi x0,x0,0), `PCD` 0, `PCPlus4D` 0, `ValidD` 0.
- PC next-state, priority high to low:
  - `reset` → `RESET_PC`.
  - `PCSrcE` → `{PCTargetE[31:2], 2'b00}`; low two bits forced to zero; overrides `StallF` and `!ImemReady`.
  - `StallF` or `!ImemReady` → hold.
  - else → `PCF + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID next-state, priority high to low:
  - `reset` → bubble.
  - `FlushD` → bubble (beats `StallD`).
  - `StallD` → hold all four outputs.
  - `StallF` (with `!StallD`) → bubble; prevents duplicating the held instruction.
  - `!ImemReady` → bubble.
  - else → `InstrD = ImemRdata`, `PCD = PCF`, `PCPlus4D = PCF + 4`, `ValidD = 1`.
- `PCSrcE` does not flush D by itself; hazard unit asserts `FlushD` alongside it.
- Redirect while `!ImemReady`: outstanding fetch abandoned, no state retained; next cycle fetches target.
- No internal FSM beyond PC and IF/ID registers; no pending-redirect storage.

## Timing
- All state updates on rising `clk`; no combinational path from any input to `PCF`, `InstrD`, `PCD`, `PCPlus4D`, `ValidD`.
- Reset values: `PCF = RESET_PC`, IF/ID = bubble; first real instruction in D one cycle after first `ImemReady=1` cycle following reset release.
- Fetch-to-decode latency: 1 cycle.
- Redirect penalty: `PCSrcE` in cycle n → `PCF = target` in n+1 → target instruction in D in n+2 (given `ImemReady`).
- Reset asserted mid-stall or mid-redirect: reset wins unconditionally that cycle.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR` constant (32'h0000_0013), `RESET_PC` default, opcode constants already used by decode.
- One sub-module: `if_id_reg` — enable/clear pipeline register (32+32+32+1 bits), clear priority over enable, synchronous reset to bubble.
- PC register, +4 adder, redirect mux inline in `fetch_stage`.

## Test plan
- Reset held 2 cycles, release with `ImemReady=1`, sequential memory → `PCF` 0,4,8; `InstrD` = word@0 one cycle after release, `ValidD` 0 during reset.
- `StallF=StallD=1` for 2 cycles at `PCF=8` → `PCF` stays 8, `InstrD`/`PCD=4` held, resumes with `PCD=8`.
- `PCSrcE=1`, `PCTargetE=32'h0000_0103`, `FlushD=1` at `PCF=0x10` → next `PCF=0x100`, `ValidD=0`, following cycle `PCD=0x100`.
- `ImemReady=0` for 3 cycles at `PCF=0x20` → `PCF` holds 0x20, D shows bubbles (`ValidD=0`, `InstrD=0x13`), then `PCD=0x20`.
- `PCSrcE=1` with `StallF=1`, `ImemReady=0`, target 0x40 → `PCF=0x40` next cycle; `FlushD=1` with `StallD=1` → bubble.
- `PCF=0xFFFF_FFFC` free-running → next `PCF=0`, `PCPlus4D` of that instruction = 0.
